// File: rtl/sd_dma_pkg.sv
// sd_dma_pkg: shared types and constants for the SD write-DMA block.
//   state_t          transfer FSM states (BUSY only reachable with SD_WDMA_BUSY_EN)
//   NIBBLE_*         nibble-counter landmarks of one 512-byte 4-bit-wide block
//   CRC16_POLY       CRC-16-CCITT polynomial x^16+x^12+x^5+1 (implicit x^16)
//   BUSY_SKIP_SDCLK  SD clocks skipped after STOP before busy sampling
package sd_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CRC,
    STOP,
    BUSY
  } state_t;

  localparam logic [10:0] NIBBLE_START     = 11'd0;
  localparam logic [10:0] NIBBLE_DATA_LAST = 11'd1024;
  localparam logic [10:0] NIBBLE_CRC_LAST  = 11'd1040;
  localparam logic [10:0] NIBBLE_STOP      = 11'd1041;

  localparam logic [15:0] CRC16_POLY       = 16'h1021;

  localparam logic [10:0] BUSY_SKIP_SDCLK  = 11'd8;

endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: serial 1-bit CRC-16 (x^16+x^12+x^5+1), initial value 0.
//   CLK  in   system clock
//   CLR  in   synchronous clear (priority over EN)
//   EN   in   shift DIN into the CRC this cycle
//   DIN  in   serial data bit
//   Q    out  current CRC value
module sd_crc16
  import sd_dma_pkg::CRC16_POLY;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        EN,
  input  logic        DIN,
  output logic [15:0] Q
);

  logic fb;

  assign fb = DIN ^ Q[15];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      Q <= '0;
    end else if (EN) begin
      Q <= {Q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_wdma.sv
// sd_wdma: streams one 512-byte block from SRAM onto the 4-bit SD data bus
// (start nibble, 1024 data nibbles, 16 CRC nibbles per line, stop nibble).
// Optional macro SD_WDMA_BUSY_EN adds a BUSY state that waits for the card
// to release DAT0 after the block.
//   CLK, RST_N        clock, synchronous active-low reset
//   SD_DMA_EN         transfer request, rising edge starts a transfer
//   SD_DMA_STATUS     high while a transfer is active
//   SD_DMA_NEXTADDR   one-CLK pulse advancing the SRAM read address
//   SD_DMA_SRAM_DATA  byte at current SRAM address
//   SD_DAT_OUT/OE     SD data lines and their output enable
//   SD_DAT0_IN        DAT0 input (busy detect, unused without SD_WDMA_BUSY_EN)
//   SD_CLK_OUT/OE     SD clock and its output enable
module sd_wdma
  import sd_dma_pkg::*;
#(
  parameter int unsigned CLK_PER_SDCLK = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SD_DMA_EN,
  output logic       SD_DMA_STATUS,
  output logic       SD_DMA_NEXTADDR,
  input  logic [7:0] SD_DMA_SRAM_DATA,
  output logic [3:0] SD_DAT_OUT,
  output logic       SD_DAT_OE,
  input  logic       SD_DAT0_IN,
  output logic       SD_CLK_OUT,
  output logic       SD_CLK_OE
);

  localparam logic [1:0] PHASE_LAST = 2'(CLK_PER_SDCLK - 1);

  state_t      state;
  logic [1:0]  phase;
  logic [1:0]  phase_nxt;
  logic [1:0]  en_sr;
  logic [10:0] nib;
  logic [10:0] nib_nxt;
  logic [7:0]  byte_q;
  logic        nib_end;
  logic        start;
  logic [3:0]  data_nib;
  logic        crc_clr;
  logic        crc_en;
  logic [15:0] crc_q [4];
  logic [3:0]  crc_bits;

  always_comb begin
    nib_end   = (phase == PHASE_LAST);
    phase_nxt = nib_end ? 2'd0 : phase + 2'd1;
    nib_nxt   = nib + 11'd1;
    start     = (en_sr == 2'b01);
    // Odd nibbles take the high half of the fresh SRAM byte, even nibbles
    // the low half of the byte latched one nibble earlier.
    data_nib  = nib_nxt[0] ? SD_DMA_SRAM_DATA[7:4] : byte_q[3:0];
    crc_clr   = !RST_N || (state == IDLE && start);
    // CRC is fed on the same edge that puts a data nibble on the bus.
    crc_en    = (state == START || state == DATA) && nib_end && (nib != NIBBLE_DATA_LAST);
  end

  for (genvar j = 0; j < 4; j++) begin : g_crc
    sd_crc16 u_crc (
      .CLK (CLK),
      .CLR (crc_clr),
      .EN  (crc_en),
      .DIN (data_nib[j]),
      .Q   (crc_q[j])
    );
    // nib is 1024..1039 when CRC nibble 1025+i is loaded, so ~nib[3:0] = 15-i.
    assign crc_bits[j] = crc_q[j][~nib[3:0]];
  end

`ifndef SD_WDMA_BUSY_EN
  logic unused_dat0;
  assign unused_dat0 = SD_DAT0_IN;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state           <= IDLE;
      phase           <= '0;
      nib             <= '0;
      en_sr           <= '0;
      byte_q          <= '0;
      SD_DMA_STATUS   <= 1'b0;
      SD_DMA_NEXTADDR <= 1'b0;
      SD_DAT_OUT      <= '1;
      SD_DAT_OE       <= 1'b0;
      SD_CLK_OUT      <= 1'b1;
      SD_CLK_OE       <= 1'b0;
    end else begin
      en_sr           <= {en_sr[0], SD_DMA_EN};
      SD_DMA_NEXTADDR <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state         <= START;
          phase         <= '0;
          nib           <= NIBBLE_START;
          SD_DMA_STATUS <= 1'b1;
          SD_DAT_OUT    <= '0;
          SD_DAT_OE     <= 1'b1;
          SD_CLK_OE     <= 1'b1;
          SD_CLK_OUT    <= 1'b0;
        end
      end else begin
        phase      <= phase_nxt;
        SD_CLK_OUT <= phase_nxt[1];
        if (state == DATA && phase == 2'd0 && nib[0]) begin
          SD_DMA_NEXTADDR <= 1'b1;
        end
        if (nib_end) begin
          nib <= nib_nxt;
          unique case (state)
            START, DATA: begin
              if (nib == NIBBLE_DATA_LAST) begin
                state      <= CRC;
                SD_DAT_OUT <= crc_bits;
              end else begin
                state      <= DATA;
                SD_DAT_OUT <= data_nib;
                if (nib_nxt[0]) begin
                  byte_q <= SD_DMA_SRAM_DATA;
                end
              end
            end
            CRC: begin
              if (nib == NIBBLE_CRC_LAST) begin
                state      <= STOP;
                nib        <= NIBBLE_STOP;
                SD_DAT_OUT <= '1;
              end else begin
                SD_DAT_OUT <= crc_bits;
              end
            end
            STOP: begin
`ifdef SD_WDMA_BUSY_EN
              state      <= BUSY;
              nib        <= '0;
              SD_DAT_OE  <= 1'b0;
              SD_DAT_OUT <= '1;
`else
              state         <= IDLE;
              phase         <= '0;
              nib           <= '0;
              SD_DMA_STATUS <= 1'b0;
              SD_DAT_OE     <= 1'b0;
              SD_CLK_OE     <= 1'b0;
              SD_CLK_OUT    <= 1'b1;
              SD_DAT_OUT    <= '1;
`endif
            end
`ifdef SD_WDMA_BUSY_EN
            BUSY: begin
              // nib counts skipped SD clocks and saturates once past the skip window.
              if (nib >= BUSY_SKIP_SDCLK) begin
                nib <= nib;
              end
            end
`endif
            default: ;
          endcase
        end
`ifdef SD_WDMA_BUSY_EN
        if (state == BUSY && phase == 2'd2 && nib >= BUSY_SKIP_SDCLK && SD_DAT0_IN) begin
          state         <= IDLE;
          phase         <= '0;
          nib           <= '0;
          SD_DMA_STATUS <= 1'b0;
          SD_CLK_OE     <= 1'b0;
          SD_CLK_OUT    <= 1'b1;
          SD_DAT_OUT    <= '1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_sd_wdma.sv
`timescale 1ns/1ps
module tb_sd_wdma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dat0 = 1'b0;
  logic       status, nextaddr, dat_oe, sdclk, sdclk_oe;
  logic [3:0] dat;
  logic [7:0] sram_data;

  logic [7:0]  mem [512];
  int unsigned addr;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_nib [1042];
  int got [$];
  int st_cnt, na_cnt, na_rise, na_bad, dat_bad, oe_bad, timeout;
  int busy_cyc, busy_lat;

`ifdef SD_WDMA_BUSY_EN
  localparam int EXP_STATUS = 4168 + 35;
`else
  localparam int EXP_STATUS = 4168;
`endif
  localparam int BUDGET = 6000;

  assign sram_data = mem[addr[8:0]];

  always #5 clk = ~clk;

  sd_wdma #(.CLK_PER_SDCLK(4)) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .SD_DMA_EN        (en),
    .SD_DMA_STATUS    (status),
    .SD_DMA_NEXTADDR  (nextaddr),
    .SD_DMA_SRAM_DATA (sram_data),
    .SD_DAT_OUT       (dat),
    .SD_DAT_OE        (dat_oe),
    .SD_DAT0_IN       (dat0),
    .SD_CLK_OUT       (sdclk),
    .SD_CLK_OE        (sdclk_oe)
  );

  task automatic chk(input string tag, input int observed, input int expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Expected bus contents from SRAM image; per-line CRC as the remainder of
  // M(x)*x^16 divided by x^16+x^12+x^5+1 (long division).
  task automatic build_exp();
    logic [1039:0] m;
    for (int i = 0; i < 1042; i++) exp_nib[i] = 0;
    for (int b = 0; b < 512; b++) begin
      exp_nib[1 + 2*b] = int'(mem[b][7:4]);
      exp_nib[2 + 2*b] = int'(mem[b][3:0]);
    end
    for (int ln = 0; ln < 4; ln++) begin
      m = '0;
      for (int k = 1; k <= 1024; k++) m[1040 - k] = exp_nib[k][ln];
      for (int p = 1039; p >= 16; p--) if (m[p]) m[p -: 17] = m[p -: 17] ^ 17'h11021;
      for (int i = 0; i < 16; i++) exp_nib[1025 + i][ln] = m[15 - i];
    end
    exp_nib[1041] = 15;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".status"},   int'(status),   0);
    chk({tag, ".nextaddr"}, int'(nextaddr), 0);
    chk({tag, ".dat"},      int'(dat),      15);
    chk({tag, ".dat_oe"},   int'(dat_oe),   0);
    chk({tag, ".sdclk"},    int'(sdclk),    1);
    chk({tag, ".sdclk_oe"}, int'(sdclk_oe), 0);
  endtask

  task automatic run_xfer(input int rst_nib, input int tog_nib, input bit hold_busy, output bit aborted);
    int cyc, tog_at, rel_at;
    bit prev_clk, prev_na;
    logic [3:0] prev_dat;
    got.delete();
    st_cnt = 0; na_cnt = 0; na_rise = 0; na_bad = 0; dat_bad = 0; oe_bad = 0; timeout = 0;
    busy_cyc = 0; busy_lat = -1; rel_at = -1;
    addr = 0; prev_clk = 1'b1; prev_na = 1'b0; prev_dat = 4'hF; aborted = 1'b0; tog_at = -1;
    @(negedge clk);
    en = 1'b1;
    cyc = 0;
    while (!status && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("xfer.start_seen", int'(status), 1);
    while (status && cyc < BUDGET) begin
      st_cnt++;
      if (nextaddr) begin
        na_cnt++;
        if (!prev_na) na_rise++;
        if (!((got.size() % 2) == 1 && got.size() <= 1023)) na_bad++;
        addr++;
      end
      prev_na = nextaddr;
      if (dat != prev_dat && !(prev_clk && !sdclk)) dat_bad++;
      if (!prev_clk && sdclk && dat_oe) got.push_back(int'(dat));
      if (!sdclk_oe) oe_bad++;
      if (got.size() < 1042 && !dat_oe) oe_bad++;
      prev_clk = sdclk;
      prev_dat = dat;
      if (got.size() >= 1042 && !dat_oe) begin
        busy_cyc++;
        if (hold_busy && busy_cyc == 400) begin
          dat0 = 1'b1;
          rel_at = cyc;
        end
      end
      if (rst_nib >= 0 && got.size() == rst_nib + 1) begin
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      if (tog_nib >= 0 && tog_at < 0 && got.size() == tog_nib + 1) begin
        en = 1'b0;
        tog_at = cyc;
      end
      if (tog_at >= 0 && cyc == tog_at + 2) en = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (status) timeout = 1;
    if (rel_at >= 0) busy_lat = cyc - rel_at;
    en = 1'b0;
  endtask

  task automatic check_xfer(input string tag, input bit chk_len);
    int mism, crc_mism;
    mism = 0;
    crc_mism = 0;
    chk({tag, ".timeout"}, timeout, 0);
    chk({tag, ".nibbles"}, got.size(), 1042);
    for (int i = 0; i < 1042 && i < got.size(); i++) begin
      if (got[i] != exp_nib[i]) begin
        mism++;
        if (i >= 1025 && i <= 1040) crc_mism++;
      end
    end
    chk({tag, ".stream_mism"}, mism, 0);
    chk({tag, ".crc_mism"}, crc_mism, 0);
    chk({tag, ".start_nib"}, got.size() > 0 ? got[0] : -1, 0);
    chk({tag, ".stop_nib"}, got.size() > 1041 ? got[1041] : -1, 15);
    chk({tag, ".nextaddr_cyc"}, na_cnt, 512);
    chk({tag, ".nextaddr_rise"}, na_rise, 512);
    chk({tag, ".nextaddr_where"}, na_bad, 0);
    chk({tag, ".dat_change_phase"}, dat_bad, 0);
    chk({tag, ".oe"}, oe_bad, 0);
    if (chk_len) chk({tag, ".status_cycles"}, st_cnt, EXP_STATUS);
    chk({tag, ".end.dat"}, int'(dat), 15);
    chk({tag, ".end.dat_oe"}, int'(dat_oe), 0);
    chk({tag, ".end.sdclk"}, int'(sdclk), 1);
    chk({tag, ".end.sdclk_oe"}, int'(sdclk_oe), 0);
  endtask

  initial begin
    bit ab;
    int idle_bad;
`ifdef SD_WDMA_BUSY_EN
    dat0 = 1'b1;
`endif
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    addr = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // All-zero block
    build_exp();
    run_xfer(-1, -1, 1'b0, ab);
    check_xfer("zero", 1'b1);
    repeat (5) @(negedge clk);

    // A5, 3C, then incrementing bytes
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    for (int i = 2; i < 512; i++) mem[i] = 8'(i);
    build_exp();
    run_xfer(-1, -1, 1'b0, ab);
    check_xfer("pattern", 1'b1);
    chk("pattern.nib1", got.size() > 4 ? got[1] : -1, 10);
    chk("pattern.nib2", got.size() > 4 ? got[2] : -1, 5);
    chk("pattern.nib3", got.size() > 4 ? got[3] : -1, 3);
    chk("pattern.nib4", got.size() > 4 ? got[4] : -1, 12);
    repeat (5) @(negedge clk);

    // Reset mid-transfer at nibble 300, then a fresh transfer
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    build_exp();
    run_xfer(300, -1, 1'b0, ab);
    chk("rst_mid.aborted", int'(ab), 1);
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (status || dat_oe || sdclk_oe || !sdclk) idle_bad++;
    end
    chk("rst_mid.no_resume", idle_bad, 0);
    run_xfer(-1, -1, 1'b0, ab);
    check_xfer("after_rst", 1'b1);
    repeat (5) @(negedge clk);

    // EN toggled during transfer must be ignored
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    build_exp();
    run_xfer(-1, 500, 1'b0, ab);
    check_xfer("toggle", 1'b1);
    repeat (5) @(negedge clk);

    // Random blocks
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      build_exp();
      run_xfer(-1, -1, 1'b0, ab);
      check_xfer($sformatf("rand%0d", t), 1'b1);
      repeat (int'($urandom_range(3, 12))) @(negedge clk);
    end

`ifdef SD_WDMA_BUSY_EN
    // Card holds DAT0 low for 100 SD clocks after STOP
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    build_exp();
    dat0 = 1'b0;
    run_xfer(-1, -1, 1'b1, ab);
    check_xfer("busy", 1'b0);
    chk("busy.held_100_sdclk", int'(busy_cyc >= 400), 1);
    chk("busy.release_latency_ok", int'(busy_lat >= 1 && busy_lat <= 4), 1);
    dat0 = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
